// File: rtl/matrix_input_mode_if.sv
// Handshake and data bus between matrix_input_mode and its UART, matrix manager and BRAM.
// master = the matrix_input_mode block; slave = the environment driving it.
interface matrix_input_mode_if #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 9
);
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     clear_rx_buffer;
  logic [7:0]               tx_data;
  logic                     tx_start;
  logic                     tx_busy;
  logic                     alloc_req;
  logic [3:0]               alloc_m;
  logic [3:0]               alloc_n;
  logic                     alloc_grant;
  logic                     alloc_fail;
  logic [ADDR_WIDTH-1:0]    alloc_addr;
  logic                     alloc_commit;
  logic                     mem_wr_en;
  logic [ADDR_WIDTH-1:0]    mem_wr_addr;
  logic [ELEMENT_WIDTH-1:0] mem_wr_data;

  modport master (
    input  rx_data, rx_valid, tx_busy, alloc_grant, alloc_fail, alloc_addr,
    output clear_rx_buffer, tx_data, tx_start, alloc_req, alloc_m, alloc_n,
           alloc_commit, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, alloc_grant, alloc_fail, alloc_addr,
    input  clear_rx_buffer, tx_data, tx_start, alloc_req, alloc_m, alloc_n,
           alloc_commit, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/matrix_input_mode.sv
// Parses "m, n, m*n elements" from UART bytes, allocates a BRAM slot, writes the
// elements, commits the slot and answers with 'K' on success or 'E' on any error.
module matrix_input_mode #(
  parameter int ELEMENT_WIDTH  = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode_active,
  input  logic [3:0]          config_max_dim,
  matrix_input_mode_if.master bus,
  output logic [3:0]          error_code,
  output logic [3:0]          sub_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_M    = 4'd1,
    GET_N    = 4'd2,
    ALLOC    = 4'd3,
    GET_ELEM = 4'd4,
    COMMIT   = 4'd5,
    SEND_ACK = 4'd6,
    ERROR    = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic [TW-1:0]            tmo;
  logic [7:0]               total;
  logic [7:0]               index;
  logic [ADDR_WIDTH-1:0]    base;
  logic                     wr_en_p1;
  logic [ADDR_WIDTH-1:0]    wr_addr_p1;
  logic [ELEMENT_WIDTH-1:0] wr_data_p1;
  logic [3:0]               fault;

  function automatic logic legal_dim(input logic [7:0] b, input logic [3:0] max_dim);
    return (b != 8'd0) && (b <= {4'd0, max_dim});
  endfunction

  function automatic logic legal_elem(input logic [7:0] b);
    return b <= 8'd9;
  endfunction

  // Error code raised this cycle (0 = none); a bad byte takes priority over a timeout.
  always_comb begin
    fault = 4'd0;
    unique case (state)
      GET_M, GET_N: begin
        if (bus.rx_valid && !legal_dim(bus.rx_data, config_max_dim)) fault = 4'd1;
        else if (!bus.rx_valid && tmo == TMO_LAST)                   fault = 4'd3;
      end
      GET_ELEM: begin
        if (bus.rx_valid && !legal_elem(bus.rx_data)) fault = 4'd2;
        else if (!bus.rx_valid && tmo == TMO_LAST)    fault = 4'd3;
      end
      ALLOC:   if (bus.alloc_fail) fault = 4'd4;
      default: fault = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      tmo                 <= '0;
      error_code          <= 4'd0;
      bus.clear_rx_buffer <= 1'b0;
      bus.tx_data         <= 8'd0;
      bus.tx_start        <= 1'b0;
      bus.alloc_req       <= 1'b0;
      bus.alloc_m         <= 4'd0;
      bus.alloc_n         <= 4'd0;
      bus.alloc_commit    <= 1'b0;
      wr_en_p1            <= 1'b0;
      wr_addr_p1          <= '0;
      wr_data_p1          <= '0;
    end else begin
      bus.clear_rx_buffer <= 1'b0;
      bus.tx_start        <= 1'b0;
      bus.alloc_commit    <= 1'b0;
      wr_en_p1            <= 1'b0;
      tmo                 <= '0;
      if (!mode_active) begin
        state         <= IDLE;
        bus.alloc_req <= 1'b0;
      end else if (fault != 4'd0) begin
        error_code          <= fault;
        bus.clear_rx_buffer <= 1'b1;
        bus.alloc_req       <= 1'b0;
        state               <= ERROR;
      end else begin
        unique case (state)
          IDLE: begin
            bus.clear_rx_buffer <= 1'b1;
            error_code          <= 4'd0;
            state               <= GET_M;
          end
          GET_M: begin
            if (bus.rx_valid) begin
              bus.alloc_m <= bus.rx_data[3:0];
              state       <= GET_N;
            end else tmo <= tmo + 1'b1;
          end
          GET_N: begin
            if (bus.rx_valid) begin
              bus.alloc_n   <= bus.rx_data[3:0];
              total         <= 8'(bus.alloc_m) * 8'(bus.rx_data[3:0]);
              bus.alloc_req <= 1'b1;
              state         <= ALLOC;
            end else tmo <= tmo + 1'b1;
          end
          ALLOC: begin
            if (bus.alloc_grant) begin
              base          <= bus.alloc_addr;
              index         <= 8'd0;
              bus.alloc_req <= 1'b0;
              state         <= GET_ELEM;
            end
          end
          // Stage p1: element accepted here is written to BRAM on the next cycle.
          GET_ELEM: begin
            if (bus.rx_valid) begin
              wr_en_p1   <= 1'b1;
              wr_addr_p1 <= base + ADDR_WIDTH'(index);
              wr_data_p1 <= ELEMENT_WIDTH'(bus.rx_data);
              index      <= index + 8'd1;
              if (index == total - 8'd1) state <= COMMIT;
            end else tmo <= tmo + 1'b1;
          end
          COMMIT: begin
            bus.alloc_commit <= 1'b1;
            state            <= SEND_ACK;
          end
          SEND_ACK: begin
            if (!bus.tx_busy) begin
              bus.tx_data  <= 8'h4B;
              bus.tx_start <= 1'b1;
              state        <= DONE;
            end
          end
          ERROR: begin
            if (!bus.tx_busy) begin
              bus.tx_data  <= 8'h45;
              bus.tx_start <= 1'b1;
              state        <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_wr_en   = wr_en_p1;
  assign bus.mem_wr_addr = wr_addr_p1;
  assign bus.mem_wr_data = wr_data_p1;
  assign sub_state       = state;

endmodule

// File: doc/matrix_input_mode.md
Name: matrix_input_mode

Overview:
- Receive-side counterpart to the compute path. It parses a matrix definition arriving byte-by-byte over UART and requests a storage slot from the matrix manager.
- It writes every element into matrix BRAM through the memory write port, commits the slot, then returns a one-byte status over UART.
- It is active only while the top-level mode FSM asserts mode_active for input mode.

Parameters:
- ELEMENT_WIDTH, 8, width of one stored matrix element.
- ADDR_WIDTH, 9, BRAM address width.
- TIMEOUT_CYCLES, 100_000_000, idle-byte timeout in clk cycles (1 s at 100 MHz).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- mode_active  input  1  input mode selected; low forces abort to IDLE
- config_max_dim  input  4  maximum legal row/column count
- rx_data  input  8  received UART byte
- rx_valid  input  1  one-cycle pulse, rx_data valid
- clear_rx_buffer  output  1  one-cycle pulse, flush receiver
- tx_data  output  8  status byte
- tx_start  output  1  one-cycle transmit strobe
- tx_busy  input  1  transmitter busy
- alloc_req  output  1  slot request, level
- alloc_m  output  4  requested rows
- alloc_n  output  4  requested cols
- alloc_grant  input  1  one-cycle pulse, allocation granted
- alloc_fail  input  1  one-cycle pulse, no slot available
- alloc_addr  input  ADDR_WIDTH  base address, valid with alloc_grant
- alloc_commit  output  1  one-cycle pulse, matrix complete
- mem_wr_en  output  1  BRAM write enable
- mem_wr_addr  output  ADDR_WIDTH  BRAM write address
- mem_wr_data  output  ELEMENT_WIDTH  BRAM write data
- error_code  output  4  0 none, 1 bad dimension, 2 bad element, 3 timeout, 4 no slot
- sub_state  output  4  current FSM state encoding

Behaviour:
- Reset (rst_n low at a clk edge) forces all outputs to 0 and state to IDLE. Reset is synchronous only.
- State encoding:
  - IDLE=0, GET_M=1, GET_N=2, ALLOC=3, GET_ELEM=4, COMMIT=5, SEND_ACK=6, ERROR=7, DONE=8.
- mode_active low: next state IDLE; alloc_req, mem_wr_en and tx_start drop to 0. No commit is issued, so any partially written data stays orphaned. error_code holds its value.
- IDLE, with mode_active high:
  - pulse clear_rx_buffer for one cycle.
  - clear error_code to 0.
  - go to GET_M.
- GET_M, on rx_valid:
  - legal when 1 <= rx_data <= config_max_dim: latch rows into alloc_m, go to GET_N.
  - otherwise: error_code=1, go to ERROR.
- GET_N: same rule, latching alloc_n. On a legal value, latch total = m*n (8-bit) and go to ALLOC.
- ALLOC:
  - hold alloc_req=1.
  - alloc_grant: latch base=alloc_addr, clear index, deassert alloc_req, go to GET_ELEM.
  - alloc_fail: error_code=4, go to ERROR.
  - grant and fail in the same cycle: fail wins.
- GET_ELEM, on rx_valid:
  - element legal when rx_data <= 9.
  - the next cycle drives mem_wr_en=1, mem_wr_addr=base+index (wraps modulo 2^ADDR_WIDTH) and mem_wr_data=rx_data[ELEMENT_WIDTH-1:0]. Write latency is exactly 1 cycle.
  - index increments. On the last element (index==total-1), go to COMMIT.
  - back-to-back rx_valid pulses are all written; no byte is lost.
  - an illegal element is not written: error_code=2, go to ERROR.
- COMMIT: pulse alloc_commit for one cycle (issued after the last write cycle), go to SEND_ACK.
- SEND_ACK: wait while tx_busy. When free, tx_data="K" (0x4B), tx_start pulse, go to DONE.
- ERROR:
  - pulse clear_rx_buffer on entry.
  - wait while tx_busy; when free, tx_data="E" (0x45), tx_start pulse, go to DONE.
  - no commit is issued.
- DONE: go to IDLE next cycle, which starts a new matrix.
- Timeout counter:
  - runs in GET_M, GET_N and GET_ELEM; reset on every rx_valid and on every state change.
  - reaching TIMEOUT_CYCLES-1 sets error_code=3 and goes to ERROR.
- rx_valid in ALLOC, COMMIT, SEND_ACK, ERROR or DONE is ignored (dropped).
- tx_start, clear_rx_buffer, alloc_commit and mem_wr_en are single-cycle pulses, never held.

Test Plan:
- Reset, config_max_dim=5, bytes 2,3 -> alloc_req with alloc_m=2, alloc_n=3. Grant with alloc_addr=0x040, then send 1..6 -> six writes at 0x040..0x045 with data 1..6, each one cycle after rx_valid; then alloc_commit pulse, then tx "K".
- Bytes 0 and then 6 with max_dim=5 -> error_code=1, no alloc_req, tx "E" after tx_busy falls.
- 1x2 matrix, elements 4,12 -> one write (data 4), error_code=2, no commit, tx "E".
- alloc_fail during ALLOC, including grant and fail in the same cycle -> error_code=4, no writes, tx "E".
- TIMEOUT_CYCLES=16, stop after the m byte -> error_code=3 sixteen cycles later. Separately, drop mode_active mid-GET_ELEM -> sub_state=0 next cycle, no commit, no tx.
- 1x1 matrix with alloc_addr=0x1FF, then a back-to-back 2x2 at base 0x1FE -> writes at 0x1FE, 0x1FF, 0x000, 0x001 (address wrap); all 4 bytes are accepted on consecutive cycles.
